elevator_motion_fsm: RTL and testbench

ELEVATOR_MOTION_FSM -- requirements
Module: elevator_motion_fsm

---
 rtl/elev_pkg.sv | 18 +
 rtl/elev_if.sv | 25 ++
 rtl/elev_timer.sv | 28 ++
 rtl/elevator_motion_fsm.sv | 159 +++++++++++++++
 tb/tb_elevator_motion_fsm.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/elev_pkg.sv
// Shared types and sizes for the elevator motion controller: state encoding,
// floor width, top floor and timer width.
package elev_pkg;

    localparam int FLOOR_W = 2;
    localparam int TMR_W   = 8;
    localparam logic [FLOOR_W-1:0] MAX_FLOOR = FLOOR_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR,
        S_HALT
    } state_t;

endpackage

// File: rtl/elev_if.sv
// Request handshake plus the floor comparator loop between the controller
// (slave) and whoever issues requests and evaluates the comparison (master).
interface elev_if;
    import elev_pkg::*;

    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;
    logic [FLOOR_W-1:0] Req_floor;
    logic [FLOOR_W-1:0] current_floor;
    logic               lt;
    logic               gt;
    logic               eq;

    modport master (
        output req_valid, req_floor, lt, gt, eq,
        input  req_ready, Req_floor, current_floor
    );

    modport slave (
        input  req_valid, req_floor, lt, gt, eq,
        output req_ready, Req_floor, current_floor
    );

endinterface

// File: rtl/elev_timer.sv
// Load / count-down / done counter shared by the move and door phases.
// done is high on the last enabled cycle of a loaded interval; en low freezes the count.
module elev_timer
    import elev_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = en && (cnt == TMR_W'(1));

endmodule

// File: rtl/elevator_motion_fsm.sv
// Single-cab motion controller; door opens 2 cycles after a same-floor request, TRAVEL_CYCLES+1 per floor.
// Accepts one request only while idle (no buffering); ELEV_ESTOP_EN adds an estop input that freezes motion.
module elevator_motion_fsm
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic clk,
    input  logic rst,
`ifdef ELEV_ESTOP_EN
    input  logic estop,
`endif
    elev_if.slave bus,
    output logic motor_up,
    output logic motor_down,
    output logic door_open,
    output logic busy,
    output logic fault
);

    state_t             state;
    state_t             next_state;
    logic               hold;
    logic               handshake;
    logic               fault_set;
    logic               floor_inc;
    logic               floor_dec;
    logic               motor_up_d;
    logic               motor_down_d;
    logic               door_open_d;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_done;
    logic [TMR_W-1:0]   tmr_val;
    logic [FLOOR_W-1:0] cur_floor_q;
    logic [FLOOR_W-1:0] tgt_floor_q;

`ifdef ELEV_ESTOP_EN
    assign hold = estop;
`else
    assign hold = 1'b0;
`endif

    assign bus.req_ready     = (state == S_IDLE) && !hold;
    assign bus.Req_floor     = tgt_floor_q;
    assign bus.current_floor = cur_floor_q;
    assign handshake         = bus.req_valid && bus.req_ready;
    assign busy              = (state != S_IDLE);

    // The timer only runs while the actuator is really driven, so a paused
    // interval resumes with exactly the cycles it had left.
    assign tmr_en = motor_up || motor_down || door_open;

    elev_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fault_set  = 1'b0;
        floor_inc  = 1'b0;
        floor_dec  = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake) next_state = S_DECIDE;
            end
            S_DECIDE: begin
                case ({bus.lt, bus.gt, bus.eq})
                    3'b010:  next_state = S_MOVE_UP;
                    3'b100:  next_state = S_MOVE_DOWN;
                    3'b001:  next_state = S_DOOR;
                    default: begin
                        next_state = S_HALT;
                        fault_set  = 1'b1;
                    end
                endcase
            end
            S_MOVE_UP: begin
                if (tmr_done) begin
                    if (cur_floor_q == MAX_FLOOR) begin
                        next_state = S_HALT;
                        fault_set  = 1'b1;
                    end else begin
                        next_state = S_DECIDE;
                        floor_inc  = 1'b1;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (tmr_done) begin
                    if (cur_floor_q == '0) begin
                        next_state = S_HALT;
                        fault_set  = 1'b1;
                    end else begin
                        next_state = S_DECIDE;
                        floor_dec  = 1'b1;
                    end
                end
            end
            S_DOOR: begin
                if (tmr_done) next_state = S_IDLE;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_HALT;
                fault_set  = 1'b1;
            end
        endcase
    end

    // Actuator values are computed for the coming cycle and registered below,
    // keeping the comparator inputs off any combinational path to them.
    always_comb begin
        motor_up_d   = (next_state == S_MOVE_UP)   && !hold;
        motor_down_d = (next_state == S_MOVE_DOWN) && !hold;
        door_open_d  = (next_state == S_DOOR)      && !hold;
        tmr_load     = (state == S_DECIDE);
        tmr_val      = (next_state == S_DOOR) ? TMR_W'(DOOR_CYCLES) : TMR_W'(TRAVEL_CYCLES);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            motor_up    <= 1'b0;
            motor_down  <= 1'b0;
            door_open   <= 1'b0;
            fault       <= 1'b0;
            cur_floor_q <= '0;
            tgt_floor_q <= '0;
        end else begin
            motor_up   <= motor_up_d;
            motor_down <= motor_down_d;
            door_open  <= door_open_d;
            fault      <= fault || fault_set;
            if (handshake) tgt_floor_q <= bus.req_floor;
            if (floor_inc) begin
                cur_floor_q <= cur_floor_q + 1'b1;
            end else if (floor_dec) begin
                cur_floor_q <= cur_floor_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_elevator_motion_fsm.sv
// Randomized and directed request sequences checked against a trip-timeline model
// derived from the per-floor and door timing rules.
module tb_elevator_motion_fsm;
    import elev_pkg::*;

    localparam int T = 4;
    localparam int D = 3;
    localparam int P = T + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       motor_up, motor_down, door_open, busy, fault;
    logic       force_en  = 1'b0;
    logic [2:0] force_cmp = 3'b000;
`ifdef ELEV_ESTOP_EN
    logic       estop = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int mf     = 0;

    always #5 clk = ~clk;

    elev_if bus();

    // Comparator alongside the DUT, with an override to inject illegal codes.
    assign {bus.lt, bus.gt, bus.eq} = force_en ? force_cmp :
        {bus.current_floor > bus.Req_floor, bus.current_floor < bus.Req_floor,
         bus.current_floor == bus.Req_floor};

    elevator_motion_fsm #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ELEV_ESTOP_EN
        .estop      (estop),
`endif
        .bus        (bus),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .busy       (busy),
        .fault      (fault)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Starts at a negedge in IDLE; model timeline relative to the handshake cycle.
    task automatic run_request(input int tgt, input bit noise);
        int n, dir, total, f, step;
        n     = (tgt > mf) ? tgt - mf : mf - tgt;
        dir   = (tgt > mf) ? 1 : -1;
        total = n * P + D + 2;
        check("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_floor = 2'(tgt);
        for (int j = 1; j <= total; j++) begin
            @(negedge clk);
            bus.req_valid = noise && (j < total) && ($urandom_range(0, 1) == 1);
            bus.req_floor = 2'($urandom_range(0, 3));
            step = ((j - 1) / P < n) ? (j - 1) / P : n;
            f    = mf + dir * step;
            check("motor_up",   motor_up,   dir > 0 && j >= 2 && j <= n * P && (j - 1) % P != 0);
            check("motor_down", motor_down, dir < 0 && j >= 2 && j <= n * P && (j - 1) % P != 0);
            check("door_open",  door_open,  j >= n * P + 2 && j <= n * P + 1 + D);
            check("busy",       busy,       j < total);
            check("req_ready",  bus.req_ready, j == total);
            check("current_floor", bus.current_floor, f);
            check("Req_floor",  bus.Req_floor, tgt);
            check("fault",      fault, 0);
        end
        bus.req_valid = 1'b0;
        mf = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        force_en = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mf = 0;
        check("ready_after_reset", bus.req_ready, 1);
        check("fault_after_reset", fault, 0);
    endtask

    task automatic nonhot_case(input logic [2:0] cmp);
        force_en = 1'b1;
        force_cmp = cmp;
        bus.req_valid = 1'b1;
        bus.req_floor = 2'd2;
        @(negedge clk);
        check("nonhot_decide_fault", fault, 0);
        check("nonhot_decide_busy", busy, 1);
        for (int j = 2; j <= 8; j++) begin
            @(negedge clk);
            bus.req_floor = 2'($urandom_range(0, 3));
            check("halt_fault", fault, 1);
            check("halt_busy", busy, 1);
            check("halt_ready", bus.req_ready, 0);
            check("halt_motors", {motor_up, motor_down, door_open}, 0);
            check("halt_Req_floor", bus.Req_floor, 2);
            check("halt_floor", bus.current_floor, mf);
        end
        do_reset();
    endtask

    task automatic wrap_case(input logic [2:0] cmp, input bit up);
        force_en = 1'b1;
        force_cmp = cmp;
        bus.req_valid = 1'b1;
        bus.req_floor = 2'(mf);
        for (int j = 1; j <= P + 1; j++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("wrap_motor_up", motor_up, up && j >= 2 && j <= P);
            check("wrap_motor_down", motor_down, !up && j >= 2 && j <= P);
            check("wrap_floor", bus.current_floor, mf);
            check("wrap_fault", fault, j == P + 1);
        end
        check("wrap_busy", busy, 1);
        do_reset();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_floor = 2'd0;
        repeat (3) @(negedge clk);
        check("in_reset_motor_up", motor_up, 0);
        check("in_reset_busy", busy, 0);
        check("in_reset_floor", bus.current_floor, 0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready", bus.req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_fault", fault, 0);
        check("reset_door", door_open, 0);
        check("reset_floor", bus.current_floor, 0);
        check("reset_Req_floor", bus.Req_floor, 0);

        run_request(0, 1'b0);
        run_request(3, 1'b0);
        run_request(1, 1'b0);

        for (int r = 0; r < 16; r++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                check("gap_ready", bus.req_ready, 1);
                check("gap_busy", busy, 0);
                check("gap_floor", bus.current_floor, mf);
            end
            run_request(int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset two cycles into an upward move from floor 1.
        run_request(1, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_floor = 2'd3;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        check("pre_reset_motor_up", motor_up, 1);
        rst = 1'b0;
        #1;
        check("async_motor_up", motor_up, 0);
        check("async_floor", bus.current_floor, 0);
        check("async_Req_floor", bus.Req_floor, 0);
        check("async_busy", busy, 0);
        check("async_door", door_open, 0);
        check("async_fault", fault, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mf = 0;
        check("post_reset_ready", bus.req_ready, 1);

        nonhot_case(3'b110);
        nonhot_case(3'b000);
        wrap_case(3'b100, 1'b0);
        run_request(3, 1'b0);
        wrap_case(3'b010, 1'b1);

`ifdef ELEV_ESTOP_EN
        begin : estop_step
            int  on_cnt;
            bit  door_seen;
            on_cnt    = 0;
            door_seen = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_floor = 2'd1;
            for (int j = 1; j <= 40 && !door_seen; j++) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                estop = (j >= 3 && j < 8);
                if (j >= 4 && j <= 8) check("estop_motor_low", motor_up, 0);
                if (motor_up) on_cnt++;
                if (door_open) door_seen = 1'b1;
            end
            estop = 1'b0;
            check("estop_motor_time", on_cnt[7:0], T);
            check("estop_door_seen", door_seen, 1);
            check("estop_floor", bus.current_floor, 1);
            repeat (D + 1) @(negedge clk);
            check("estop_idle_ready", bus.req_ready, 1);
            do_reset();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
